id_ex_stage: RTL

ID/EX pipeline stage sitting directly upstream of the ALU in the pipelined RV32I core. It registers the decoded instruction bundle and resolves operand forwarding from MEM and WB, driving the ALU's `a`, `b` and `alu_ctrl` inputs. It also detects load-use hazards, stalling decode, and inserts bubbles on stall or branch flush.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/id_ex_stage_if.sv | 60 ++++++
 rtl/fwd_mux.sv | 32 +++
 rtl/id_ex_stage.sv | 114 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants: register-address width, ALU op codes and
// writeback result-source selects.
package riscv_pkg;

  localparam int unsigned RA_W = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between decode, the ID/EX stage, the MEM/WB forward sources and the ALU.
// The master side drives decode and forwarding inputs; the stage is the slave.
interface id_ex_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RA_W  = riscv_pkg::RA_W
);

  logic             id_valid;
  logic [WIDTH-1:0] id_rd_data1;
  logic [WIDTH-1:0] id_rd_data2;
  logic [WIDTH-1:0] id_imm_ext;
  logic [RA_W-1:0]  id_rs1;
  logic [RA_W-1:0]  id_rs2;
  logic [RA_W-1:0]  id_rd;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [2:0]       id_alu_ctrl;
  logic             id_alu_src;
  logic             id_reg_write;
  logic             id_mem_write;
  logic [1:0]       id_result_src;
  logic             flush;

  logic             mem_reg_write;
  logic [RA_W-1:0]  mem_rd;
  logic [WIDTH-1:0] mem_alu_result;
  logic             wb_reg_write;
  logic [RA_W-1:0]  wb_rd;
  logic [WIDTH-1:0] wb_result;

  logic             stall;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] ex_write_data;
  logic             ex_valid;
  logic [RA_W-1:0]  ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_write;
  logic [1:0]       ex_result_src;

  modport master (
    output id_valid, id_rd_data1, id_rd_data2, id_imm_ext, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_alu_ctrl, id_alu_src, id_reg_write, id_mem_write,
           id_result_src, flush, mem_reg_write, mem_rd, mem_alu_result, wb_reg_write,
           wb_rd, wb_result,
    input  stall, alu_a, alu_b, alu_ctrl, ex_write_data, ex_valid, ex_rd, ex_reg_write,
           ex_mem_write, ex_result_src
  );

  modport slave (
    input  id_valid, id_rd_data1, id_rd_data2, id_imm_ext, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_alu_ctrl, id_alu_src, id_reg_write, id_mem_write,
           id_result_src, flush, mem_reg_write, mem_rd, mem_alu_result, wb_reg_write,
           wb_rd, wb_result,
    output stall, alu_a, alu_b, alu_ctrl, ex_write_data, ex_valid, ex_rd, ex_reg_write,
           ex_mem_write, ex_result_src
  );

endinterface

// File: rtl/fwd_mux.sv
// Operand forwarding select: youngest in-flight writer of the source register wins,
// falling back to the value read at decode. Register x0 is never forwarded.
module fwd_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RA_W  = riscv_pkg::RA_W
) (
  input  logic [RA_W-1:0]  src_idx,
  input  logic [WIDTH-1:0] reg_val,
  input  logic             mem_en,
  input  logic [RA_W-1:0]  mem_idx,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             wb_en,
  input  logic [RA_W-1:0]  wb_idx,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] operand
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = mem_en && (mem_idx != '0) && (mem_idx == src_idx);
    wb_hit  = wb_en && (wb_idx != '0) && (wb_idx == src_idx);
    operand = reg_val;
    if (mem_hit) begin
      operand = mem_data;
    end else if (wb_hit) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, decode-time WB bypass and
// MEM/WB operand forwarding feeding the ALU.
module id_ex_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RA_W  = riscv_pkg::RA_W
) (
  input logic          clk,
  input logic          reset_n,
  id_ex_stage_if.slave bus
);
  import riscv_pkg::*;

  typedef struct packed {
    logic             valid;
    logic [RA_W-1:0]  rs1;
    logic [RA_W-1:0]  rs2;
    logic [RA_W-1:0]  rd;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;
    logic [WIDTH-1:0] imm;
    logic [2:0]       alu_ctrl;
    logic             alu_src;
    logic             reg_write;
    logic             mem_write;
    logic [1:0]       result_src;
  } ex_bundle_t;

  ex_bundle_t       ex_q, ex_d;
  logic             load_in_ex;
  logic             src_hit;
  logic             stall_c;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;

  always_comb begin
    load_in_ex = ex_q.valid && ex_q.reg_write && (ex_q.result_src == RES_LOAD) &&
                 (ex_q.rd != '0);
    src_hit    = (bus.id_uses_rs1 && (bus.id_rs1 == ex_q.rd)) ||
                 (bus.id_uses_rs2 && (bus.id_rs2 == ex_q.rd));
    stall_c    = load_in_ex && bus.id_valid && !bus.flush && src_hit;
  end

  // Flush, stall and an empty decode slot all leave an all-zero bubble.
  always_comb begin
    ex_d = '0;
    if (!bus.flush && !stall_c && bus.id_valid) begin
      ex_d.valid      = 1'b1;
      ex_d.rs1        = bus.id_rs1;
      ex_d.rs2        = bus.id_rs2;
      ex_d.rd         = bus.id_rd;
      ex_d.imm        = bus.id_imm_ext;
      ex_d.alu_ctrl   = bus.id_alu_ctrl;
      ex_d.alu_src    = bus.id_alu_src;
      ex_d.reg_write  = bus.id_reg_write;
      ex_d.mem_write  = bus.id_mem_write;
      ex_d.result_src = bus.id_result_src;
      // WB writes the register file this same edge, so the decode read is stale.
      ex_d.rd_data1 = (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs1)) ?
                      bus.wb_result : bus.id_rd_data1;
      ex_d.rd_data2 = (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs2)) ?
                      bus.wb_result : bus.id_rd_data2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_mux #(
    .WIDTH (WIDTH),
    .RA_W  (RA_W)
  ) u_fwd_a (
    .src_idx  (ex_q.rs1),
    .reg_val  (ex_q.rd_data1),
    .mem_en   (bus.mem_reg_write),
    .mem_idx  (bus.mem_rd),
    .mem_data (bus.mem_alu_result),
    .wb_en    (bus.wb_reg_write),
    .wb_idx   (bus.wb_rd),
    .wb_data  (bus.wb_result),
    .operand  (fwd_a)
  );

  fwd_mux #(
    .WIDTH (WIDTH),
    .RA_W  (RA_W)
  ) u_fwd_b (
    .src_idx  (ex_q.rs2),
    .reg_val  (ex_q.rd_data2),
    .mem_en   (bus.mem_reg_write),
    .mem_idx  (bus.mem_rd),
    .mem_data (bus.mem_alu_result),
    .wb_en    (bus.wb_reg_write),
    .wb_idx   (bus.wb_rd),
    .wb_data  (bus.wb_result),
    .operand  (fwd_b)
  );

  assign bus.stall         = stall_c;
  assign bus.alu_a         = fwd_a;
  assign bus.alu_b         = ex_q.alu_src ? ex_q.imm : fwd_b;
  assign bus.ex_write_data = fwd_b;
  assign bus.alu_ctrl      = ex_q.alu_ctrl;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_result_src = ex_q.result_src;

endmodule
